vec_alu_exec: RTL and testbench



---
 rtl/vec_alu_pkg.sv | 84 ++++++++
 rtl/vec_alu_lane.sv | 51 +++++
 rtl/vec_alu_exec.sv | 156 +++++++++++++++
 tb/tb_vec_alu_exec.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_alu_pkg.sv
// Shared types, sizes and the per-element ALU function for the vector integer execution stage.
package vec_alu_pkg;

    localparam int unsigned MAX_VLEN    = 4096;
    localparam int unsigned VLEN        = 512;
    localparam int unsigned CHUNK_WIDTH = 128;
    localparam int unsigned XLEN        = 32;

    localparam int unsigned NUM_CHUNKS = MAX_VLEN / CHUNK_WIDTH;
    localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS);
    localparam int unsigned NCH_W      = CNT_W + 1;
    localparam int unsigned ELEMS8     = CHUNK_WIDTH / 8;
    localparam int unsigned ELEMS16    = CHUNK_WIDTH / 16;
    localparam int unsigned ELEMS32    = CHUNK_WIDTH / 32;
    localparam int unsigned VLEFF_W    = $clog2(VLEN) + 1;
    localparam int unsigned BITS_W     = $clog2(MAX_VLEN) + 1;
    localparam int unsigned MIDX_W     = $clog2(VLEN);

    localparam logic [6:0] SEW8  = 7'd8;
    localparam logic [6:0] SEW16 = 7'd16;
    localparam logic [6:0] SEW32 = 7'd32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_RSUB = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_MINU = 4'd9,
        ALU_MAXU = 4'd10,
        ALU_MIN  = 4'd11,
        ALU_MAX  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] sext(input logic [31:0] v, input logic [6:0] sew);
        case (sew)
            SEW8:    sext = {{24{v[7]}}, v[7:0]};
            SEW16:   sext = {{16{v[15]}}, v[15:0]};
            default: sext = v;
        endcase
    endfunction

    // a and b arrive zero-extended from sew bits; caller truncates the return value to sew.
    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [6:0] sew);
        logic [4:0]  sh;
        logic [31:0] as;
        logic [31:0] bs;
        case (sew)
            SEW8:    sh = {2'b00, a[2:0]};
            SEW16:   sh = {1'b0, a[3:0]};
            default: sh = a[4:0];
        endcase
        as = sext(a, sew);
        bs = sext(b, sew);
        case (op)
            ALU_ADD:  alu_calc = b + a;
            ALU_SUB:  alu_calc = b - a;
            ALU_RSUB: alu_calc = a - b;
            ALU_AND:  alu_calc = b & a;
            ALU_OR:   alu_calc = b | a;
            ALU_XOR:  alu_calc = b ^ a;
            ALU_SLL:  alu_calc = b << sh;
            ALU_SRL:  alu_calc = b >> sh;
            ALU_SRA:  alu_calc = $signed(bs) >>> sh;
            ALU_MINU: alu_calc = (b < a) ? b : a;
            ALU_MAXU: alu_calc = (b > a) ? b : a;
            ALU_MIN:  alu_calc = ($signed(bs) < $signed(as)) ? b : a;
            ALU_MAX:  alu_calc = ($signed(bs) > $signed(as)) ? b : a;
            default:  alu_calc = b;
        endcase
    endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational SIMD unit: computes one CHUNK_WIDTH slice and merges it with dst under body/mask policy.
module vec_alu_lane
    import vec_alu_pkg::*;
(
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic [CHUNK_WIDTH-1:0] dst,
    input  logic [ELEMS8-1:0]      body,
    input  logic [ELEMS8-1:0]      en,
    input  logic [6:0]             sew,
    input  logic [3:0]             op,
    input  logic                   mask_agnostic,
    output logic [CHUNK_WIDTH-1:0] merged_c
);

    logic [31:0] el;

    // body selects non-tail elements; en clear means masked off
    always_comb begin
        merged_c = dst;
        el       = '0;
        case (sew)
            SEW8: begin
                for (int j = 0; j < int'(ELEMS8); j++) begin
                    el = alu_calc(op, 32'(a[j*8 +: 8]), 32'(b[j*8 +: 8]), sew);
                    if (body[j])
                        merged_c[j*8 +: 8] = en[j] ? el[7:0] :
                                             (mask_agnostic ? 8'hFF : dst[j*8 +: 8]);
                end
            end
            SEW16: begin
                for (int j = 0; j < int'(ELEMS16); j++) begin
                    el = alu_calc(op, 32'(a[j*16 +: 16]), 32'(b[j*16 +: 16]), sew);
                    if (body[j])
                        merged_c[j*16 +: 16] = en[j] ? el[15:0] :
                                               (mask_agnostic ? 16'hFFFF : dst[j*16 +: 16]);
                end
            end
            SEW32: begin
                for (int j = 0; j < int'(ELEMS32); j++) begin
                    el = alu_calc(op, a[j*32 +: 32], b[j*32 +: 32], sew);
                    if (body[j])
                        merged_c[j*32 +: 32] = en[j] ? el :
                                               (mask_agnostic ? 32'hFFFF_FFFF : dst[j*32 +: 32]);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vec_alu_exec.sv
// Vector integer execution stage: walks the register group one chunk per cycle into the result register.
module vec_alu_exec
    import vec_alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          alu_op,
    input  logic [6:0]          sew,
    input  logic [XLEN-1:0]     vl,
    input  logic                vm,
    input  logic                mask_agnostic,
    input  logic                scalar_a,
    input  logic [MAX_VLEN-1:0] op_a,
    input  logic [MAX_VLEN-1:0] op_b,
    input  logic [MAX_VLEN-1:0] dst_data,
    input  logic [VLEN-1:0]     v0_mask,
    output logic [MAX_VLEN-1:0] result,
    output logic                busy,
    output logic                alu_done,
    output logic                alu_err
);

    state_e                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, last_cnt;
    logic                   busy_nxt, done_nxt, err_nxt, load_dst, write_chunk;
    logic                   sew_legal;
    logic [VLEFF_W-1:0]     max_elems, vl_eff;
    logic [BITS_W-1:0]      total_bits;
    logic [NCH_W-1:0]       num_chunks;
    int unsigned            epc;
    logic [MIDX_W-1:0]      idx;
    logic [ELEMS8-1:0]      body, en;
    logic [CHUNK_WIDTH-1:0] a_bcast, a_chunk, lane_out;

    // effective element count and number of chunks to process
    always_comb begin
        sew_legal = 1'b1;
        max_elems = '0;
        case (sew)
            SEW8:    max_elems = VLEFF_W'(MAX_VLEN / 8);
            SEW16:   max_elems = VLEFF_W'(MAX_VLEN / 16);
            SEW32:   max_elems = VLEFF_W'(MAX_VLEN / 32);
            default: sew_legal = 1'b0;
        endcase
        vl_eff     = (vl > XLEN'(max_elems)) ? max_elems : VLEFF_W'(vl);
        total_bits = BITS_W'(vl_eff) * BITS_W'(sew);
        num_chunks = NCH_W'((total_bits + BITS_W'(CHUNK_WIDTH - 1)) / BITS_W'(CHUNK_WIDTH));
        last_cnt   = CNT_W'(num_chunks - NCH_W'(1));
    end

    // per-element tail and mask enables for the current chunk
    always_comb begin
        case (sew)
            SEW8:    epc = ELEMS8;
            SEW16:   epc = ELEMS16;
            default: epc = ELEMS32;
        endcase
        idx  = '0;
        body = '0;
        en   = '0;
        for (int j = 0; j < int'(ELEMS8); j++) begin
            if (32'(j) < epc) begin
                idx     = MIDX_W'(32'(cnt) * epc + 32'(j));
                body[j] = VLEFF_W'(idx) < vl_eff;
                en[j]   = vm | v0_mask[idx];
            end
        end
    end

    always_comb begin
        case (sew)
            SEW8:    a_bcast = {ELEMS8{op_a[7:0]}};
            SEW16:   a_bcast = {ELEMS16{op_a[15:0]}};
            default: a_bcast = {ELEMS32{op_a[31:0]}};
        endcase
        a_chunk = scalar_a ? a_bcast : op_a[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
    end

    vec_alu_lane u_lane (
        .a             (a_chunk),
        .b             (op_b[cnt*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .dst           (dst_data[cnt*CHUNK_WIDTH +: CHUNK_WIDTH]),
        .body          (body),
        .en            (en),
        .sew           (sew),
        .op            (alu_op),
        .mask_agnostic (mask_agnostic),
        .merged_c      (lane_out)
    );

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        load_dst    = 1'b0;
        write_chunk = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_dst = 1'b1;
                    cnt_nxt  = '0;
                    busy_nxt = 1'b1;
                    if (sew_legal && vl != '0) begin
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = !sew_legal;
                    end
                end
            end
            EXEC: begin
                write_chunk = 1'b1;
                cnt_nxt     = cnt + CNT_W'(1);
                if (cnt == last_cnt) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            alu_done <= 1'b0;
            alu_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            busy     <= busy_nxt;
            alu_done <= done_nxt;
            alu_err  <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            result <= '0;
        else if (load_dst)
            result <= dst_data;
        else if (write_chunk)
            result[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] <= lane_out;
    end

endmodule

// File: tb/tb_vec_alu_exec.sv
// Randomized scoreboard bench for vec_alu_exec against an element-level reference model.
module tb_vec_alu_exec;
    import vec_alu_pkg::*;

    localparam int MV = 4096;

    logic           clk = 1'b0;
    logic           reset, start, vm, mask_agnostic, scalar_a;
    logic [3:0]     alu_op;
    logic [6:0]     sew;
    logic [31:0]    vl;
    logic [MV-1:0]  op_a, op_b, dst_data, result;
    logic [511:0]   v0_mask;
    logic           busy, alu_done, alu_err;

    logic [MV-1:0]  ta, tb, td;
    logic [511:0]   tm;
    int             cyc = 0;
    int             n_err = 0;
    int             n_checks = 0;

    typedef struct {
        logic [MV-1:0] res;
        logic          err;
        int            due;
    } exp_t;
    exp_t sb[$];

    vec_alu_exec dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .sew(sew), .vl(vl),
        .vm(vm), .mask_agnostic(mask_agnostic), .scalar_a(scalar_a), .op_a(op_a),
        .op_b(op_b), .dst_data(dst_data), .v0_mask(v0_mask), .result(result),
        .busy(busy), .alu_done(alu_done), .alu_err(alu_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // element-by-element reference built directly from the operation rules
    function automatic logic [MV-1:0] model(input int op, input int sw, input int vlv,
            input bit vmv, input bit agn, input bit scal, input logic [MV-1:0] av,
            input logic [MV-1:0] bv, input logic [MV-1:0] dv, input logic [511:0] mv);
        logic [MV-1:0] res, tmp, clr;
        longint mask, half, a, b, d, r, sa, sbv;
        int nel, vle, sh;
        res = dv;
        if (!(sw == 8 || sw == 16 || sw == 32) || vlv == 0) return res;
        nel  = MV / sw;
        vle  = (vlv < nel) ? vlv : nel;
        mask = (longint'(1) << sw) - 1;
        half = longint'(1) << (sw - 1);
        for (int i = 0; i < vle; i++) begin
            tmp = bv >> (i * sw);              b = longint'(tmp[31:0]) & mask;
            tmp = dv >> (i * sw);              d = longint'(tmp[31:0]) & mask;
            tmp = av >> (scal ? 0 : i * sw);   a = longint'(tmp[31:0]) & mask;
            sa  = (a >= half) ? a - (mask + 1) : a;
            sbv = (b >= half) ? b - (mask + 1) : b;
            sh  = int'(a % longint'(sw));
            if (!vmv && !mv[i]) r = agn ? mask : d;
            else begin
                case (op)
                    0:  r = b + a;
                    1:  r = b - a;
                    2:  r = a - b;
                    3:  r = b & a;
                    4:  r = b | a;
                    5:  r = b ^ a;
                    6:  r = b << sh;
                    7:  r = b >> sh;
                    8:  r = sbv >>> sh;
                    9:  r = (b < a) ? b : a;
                    10: r = (b > a) ? b : a;
                    11: r = (sbv < sa) ? b : a;
                    12: r = (sbv > sa) ? b : a;
                    default: r = b;
                endcase
            end
            r   = r & mask;
            clr = MV'(mask) << (i * sw);
            res = (res & ~clr) | (MV'(r) << (i * sw));
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drive one request at a negedge and push its expectation; does not wait
    task automatic issue(input int op, input int sw, input int vlv, input bit vmv,
                         input bit agn, input bit scal);
        exp_t e;
        int nel, vle, n;
        alu_op = 4'(op); sew = 7'(sw); vl = 32'(vlv);
        vm = vmv; mask_agnostic = agn; scalar_a = scal;
        op_a = ta; op_b = tb; dst_data = td; v0_mask = tm;
        n = 0;
        if ((sw == 8 || sw == 16 || sw == 32) && vlv != 0) begin
            nel = MV / sw;
            vle = (vlv < nel) ? vlv : nel;
            n   = (vle * sw + 127) / 128;
        end
        e.res = model(op, sw, vlv, vmv, agn, scal, ta, tb, td, tm);
        e.err = !(sw == 8 || sw == 16 || sw == 32);
        e.due = cyc + 1 + n;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout: %0d responses outstanding after %0d cycles, expected 0", sb.size(), t);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic rand_vec(output logic [MV-1:0] v);
        for (int i = 0; i < MV / 32; i++) v[i*32 +: 32] = $urandom;
    endtask

    // monitor: compare each completion against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && alu_done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done: alu_done=1 at cycle %0d, expected no completion", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.due));
                    chk("alu_err", 64'(alu_err), 64'(e.err));
                    chk("busy_at_done", 64'(busy), 64'd1);
                    n_checks++;
                    if (result !== e.res) begin
                        n_err++;
                        for (int k = 0; k < MV / 32; k++) begin
                            if (result[k*32 +: 32] !== e.res[k*32 +: 32]) begin
                                $display("FAIL result word %0d: got %h expected %h",
                                         k, result[k*32 +: 32], e.res[k*32 +: 32]);
                                break;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int op, sw, vlv;
        reset = 1'b1; start = 1'b0; alu_op = '0; sew = 7'd8; vl = '0;
        vm = 1'b1; mask_agnostic = 1'b0; scalar_a = 1'b0;
        op_a = '0; op_b = '0; dst_data = '0; v0_mask = '0;
        ta = '0; tb = '0; td = '0; tm = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(alu_done), 64'd0);
        chk("reset_err", 64'(alu_err), 64'd0);
        chk("reset_result", 64'(result[63:0]), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic add, two-chunk latency
        for (int i = 0; i < MV / 32; i++) begin
            ta[i*32 +: 32] = 32'(i); tb[i*32 +: 32] = 32'd100; td[i*32 +: 32] = 32'hDEADBEEF;
        end
        issue(0, 32, 8, 1'b1, 1'b0, 1'b0); wait_done();
        chk("add_e0", 64'(result[31:0]), 64'd100);
        chk("add_e7", 64'(result[255:224]), 64'd107);
        chk("add_e8", 64'(result[287:256]), 64'hDEADBEEF);
        chk("add_top", 64'(result[MV-1 -: 32]), 64'hDEADBEEF);

        // masked sub, undisturbed then agnostic
        ta = {512{8'h20}}; tb = {512{8'h10}}; td = {512{8'h77}}; tm = 512'h5555;
        issue(1, 8, 16, 1'b0, 1'b0, 1'b0); wait_done();
        chk("sub_even", 64'(result[7:0]), 64'hF0);
        chk("sub_odd_tu", 64'(result[15:8]), 64'h77);
        issue(1, 8, 16, 1'b0, 1'b1, 1'b0); wait_done();
        chk("sub_odd_ta", 64'(result[15:8]), 64'hFF);
        chk("sub_tail", 64'(result[135:128]), 64'h77);

        // scalar-broadcast arithmetic shift
        ta = '0; ta[31:0] = 32'h0000_0013; tb = {256{16'h8000}}; td = {256{16'h1234}}; tm = '0;
        issue(8, 16, 4, 1'b1, 1'b0, 1'b1); wait_done();
        chk("sra_e0_3", 64'(result[63:0]), 64'hF000_F000_F000_F000);
        chk("sra_tail", 64'(result[79:64]), 64'h1234);

        // vl==0 and illegal sew pass dst through
        rand_vec(ta); rand_vec(tb); rand_vec(td);
        issue(0, 32, 0, 1'b1, 1'b0, 1'b0); wait_done();
        issue(0, 64, 5, 1'b1, 1'b0, 1'b0); wait_done();
        chk("sew64_result", 64'(result[63:0]), td[63:0]);

        // clamp to 512 elements, with a second start ignored mid-operation
        ta = {512{8'h01}}; tb = {512{8'h02}}; rand_vec(td);
        issue(0, 8, 1000, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy_mid", 64'(busy), 64'd1);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done();
        chk("clamp_top", 64'(result[MV-1 -: 8]), 64'h03);

        // async reset mid-operation, then a normal run
        issue(0, 8, 1000, 1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(alu_done), 64'd0);
        chk("rst_result", 64'(result[MV-1 -: 64]), 64'd0);
        sb.delete();
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        issue(1, 16, 20, 1'b1, 1'b0, 1'b0); wait_done();

        // signed vs unsigned min
        ta = '0; ta[31:0] = 32'hFFFF_FFFF; tb = '0; tb[31:0] = 32'd1; td = '0;
        issue(11, 32, 1, 1'b1, 1'b0, 1'b0); wait_done();
        chk("min_signed", 64'(result[31:0]), 64'hFFFF_FFFF);
        issue(9, 32, 1, 1'b1, 1'b0, 1'b0); wait_done();
        chk("minu", 64'(result[31:0]), 64'd1);

        // randomized operations
        for (int t = 0; t < 40; t++) begin
            rand_vec(ta); rand_vec(tb); rand_vec(td);
            for (int i = 0; i < 16; i++) tm[i*32 +: 32] = $urandom;
            op = int'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2: sw = 8;
                3, 4, 5: sw = 16;
                6, 7, 8: sw = 32;
                default: sw = 64;
            endcase
            vlv = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40))
                                              : int'($urandom_range(0, 600));
            issue(op, sw, vlv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
